// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer write port of the UART transmit queue
interface uart_tx_fifo_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    wr_valid;
   logic                    wr_ready;
   logic [PAYLOAD_BITS-1:0] wr_data;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular transmit queue feeding a UART enable/busy interface
module uart_tx_fifo #(
   parameter int  PAYLOAD_BITS = 8,
   parameter int  DEPTH        = 16,
   localparam int ADDR_BITS    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    flush,
   uart_tx_fifo_if.slave           wr_if,
   output logic [ADDR_BITS:0]      fifo_count,
   output logic                    fifo_empty,
   output logic                    fifo_full,
   output logic                    tx_idle,
   input  logic                    uart_tx_busy,
   output logic                    uart_tx_en,
   output logic [PAYLOAD_BITS-1:0] uart_tx_data
);
   localparam int CW = ADDR_BITS + 1;
   localparam logic [ADDR_BITS:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      F_IDLE      = 2'd0,
      F_LAUNCH    = 2'd1,
      F_WAIT_BUSY = 2'd2,
      F_WAIT_DONE = 2'd3
   } feed_state_t;

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];

   logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]      count_q, count_d;
   feed_state_t             state_q, state_d;
   logic                    tx_en_q, tx_en_d;
   logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
   logic                    push, launch;

   assign fifo_count     = count_q;
   assign fifo_empty     = (count_q == '0);
   assign fifo_full      = (count_q == FULL_COUNT);
   assign wr_if.wr_ready = !fifo_full;
   assign tx_idle        = fifo_empty && (state_q == F_IDLE) && !uart_tx_busy;
   assign uart_tx_en     = tx_en_q;
   assign uart_tx_data   = tx_data_q;

   // Flush suppresses both the push and the launch/pop on its edge.
   assign push   = wr_if.wr_valid && !fifo_full && !flush;
   assign launch = (state_q == F_IDLE) && !fifo_empty && !uart_tx_busy && !flush;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q + CW'(push) - CW'(launch);
      state_d   = state_q;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;

      if (push)   wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      if (launch) rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      // The feeder is deliberately untouched by flush so a launched item completes.
      case (state_q)
         F_IDLE: begin
            if (launch) begin
               tx_data_d = mem[rd_ptr_q];
               tx_en_d   = 1'b1;
               state_d   = F_LAUNCH;
            end
         end
         F_LAUNCH:    state_d = F_WAIT_BUSY;
         F_WAIT_BUSY: if (uart_tx_busy)  state_d = F_WAIT_DONE;
         F_WAIT_DONE: if (!uart_tx_busy) state_d = F_IDLE;
         default:     state_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= F_IDLE;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_if.wr_data;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
   localparam int PB  = 8;
   localparam int DEP = 16;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       flush = 1'b0;
   logic [4:0] fifo_count;
   logic       fifo_empty, fifo_full, tx_idle;
   logic       uart_tx_busy, uart_tx_en;
   logic [7:0] uart_tx_data;

   uart_tx_fifo_if #(.PAYLOAD_BITS(PB)) wr_if ();

   uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEP)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .wr_if        (wr_if),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .tx_idle      (tx_idle),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy rises the edge after the enable, lasts 10 bit times.
   logic       model_busy = 1'b0;
   logic       hold_busy = 1'b0;
   logic       prev_en = 1'b0;
   int         bit_cnt = 0;
   logic [7:0] rx_q [$];
   int         en_pulses = 0;
   int         en_double = 0;
   int         peak = 0;

   assign uart_tx_busy = model_busy | hold_busy;

   always @(posedge clk) begin
      if (!resetn) begin
         model_busy <= 1'b0;
         bit_cnt    <= 0;
         prev_en    <= 1'b0;
      end else begin
         prev_en <= uart_tx_en;
         if (uart_tx_en && prev_en) en_double++;
         if (uart_tx_en) begin
            rx_q.push_back(uart_tx_data);
            en_pulses++;
            model_busy <= 1'b1;
            bit_cnt    <= CPB * 10 - 1;
         end else if (model_busy) begin
            if (bit_cnt == 0) model_busy <= 1'b0;
            else              bit_cnt <= bit_cnt - 1;
         end
      end
   end

   always @(negedge clk) if (int'(fifo_count) > peak) peak = int'(fifo_count);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = d;
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic push_retry(input logic [7:0] d);
      logic acc;
      acc = 1'b0;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = d;
      for (int i = 0; i < 3000; i++) begin
         acc = wr_if.wr_ready;
         @(negedge clk);
         if (acc) break;
      end
      wr_if.wr_valid = 1'b0;
      if (!acc) chk("push_timeout", 32'(acc), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (tx_idle) break;
         @(negedge clk);
      end
      chk(tag, 32'(tx_idle), 32'd1);
   endtask

   task automatic clear_obs();
      rx_q.delete();
      en_pulses = 0;
      en_double = 0;
      peak      = 0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_cnt;
      int bad;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = 8'h00;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_ready", 32'(wr_if.wr_ready), 32'd1);
      chk("rst_en", 32'(uart_tx_en), 32'd0);
      chk("rst_data", 32'(uart_tx_data), 32'd0);
      chk("rst_idle", 32'(tx_idle), 32'd1);

      // Test 1: three back-to-back pushes, launch latency and order.
      clear_obs();
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'h41;
      @(negedge clk);
      chk("t1_en_after_push", 32'(uart_tx_en), 32'd0);
      wr_if.wr_data = 8'h42;
      @(negedge clk);
      chk("t1_en_launch", 32'(uart_tx_en), 32'd1);
      chk("t1_data_launch", 32'(uart_tx_data), 32'h41);
      wr_if.wr_data = 8'h43;
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      chk("t1_en_single", 32'(uart_tx_en), 32'd0);
      chk("t1_count2", 32'(fifo_count), 32'd2);
      wait_idle("t1_idle", 400);
      chk("t1_rx_n", 32'(rx_q.size()), 32'd3);
      chk("t1_rx0", 32'(rx_q[0]), 32'h41);
      chk("t1_rx1", 32'(rx_q[1]), 32'h42);
      chk("t1_rx2", 32'(rx_q[2]), 32'h43);
      chk("t1_pulses", 32'(en_pulses), 32'd3);
      chk("t1_peak", 32'(peak), 32'd2);
      chk("t1_count0", 32'(fifo_count), 32'd0);

      // Test 2: fill while the transmitter is held busy.
      clear_obs();
      hold_busy = 1'b1;
      acc_cnt = 0;
      for (int i = 0; i < DEP + 2; i++) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_data  = 8'(i);
         if (wr_if.wr_ready) acc_cnt++;
         @(negedge clk);
      end
      wr_if.wr_valid = 1'b0;
      chk("t2_accepted", 32'(acc_cnt), 32'd16);
      chk("t2_full", 32'(fifo_full), 32'd1);
      chk("t2_ready", 32'(wr_if.wr_ready), 32'd0);
      chk("t2_count", 32'(fifo_count), 32'd16);
      chk("t2_no_launch", 32'(en_pulses), 32'd0);
      hold_busy = 1'b0;
      push_retry(8'h10);
      push_retry(8'h11);
      wait_idle("t2_idle", 2000);
      chk("t2_rx_n", 32'(rx_q.size()), 32'd18);
      bad = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != 8'(i)) bad++;
      chk("t2_order", 32'(bad), 32'd0);

      // Test 3: 40 items across pointer wrap with draining in between.
      clear_obs();
      for (int i = 0; i < 40; i++) begin
         push_retry(8'(8'h80 + i));
         if (i % 7 == 6) repeat (30) @(negedge clk);
      end
      wait_idle("t3_idle", 3000);
      chk("t3_rx_n", 32'(rx_q.size()), 32'd40);
      bad = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != 8'(8'h80 + i)) bad++;
      chk("t3_order", 32'(bad), 32'd0);
      chk("t3_peak", 32'(peak), 32'd16);
      chk("t3_double", 32'(en_double), 32'd0);

      // Test 4: simultaneous push and pop at count 5.
      do_reset();
      clear_obs();
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
      chk("t4_count5", 32'(fifo_count), 32'd5);
      chk("t4_wptr_pre", 32'(dut.wr_ptr_q), 32'd5);
      chk("t4_rptr_pre", 32'(dut.rd_ptr_q), 32'd0);
      hold_busy = 1'b0;
      push(8'hC5);
      chk("t4_count_same", 32'(fifo_count), 32'd5);
      chk("t4_wptr_post", 32'(dut.wr_ptr_q), 32'd6);
      chk("t4_rptr_post", 32'(dut.rd_ptr_q), 32'd1);
      chk("t4_en", 32'(uart_tx_en), 32'd1);
      chk("t4_data", 32'(uart_tx_data), 32'hC0);
      wait_idle("t4_idle", 1000);
      bad = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != 8'(8'hC0 + i)) bad++;
      chk("t4_rx_n", 32'(rx_q.size()), 32'd6);
      chk("t4_order", 32'(bad), 32'd0);

      // Test 5: flush while an item is on the wire.
      clear_obs();
      push(8'h55);
      repeat (5) @(negedge clk);
      push(8'h66);
      push(8'h77);
      push(8'h88);
      chk("t5_count3", 32'(fifo_count), 32'd3);
      chk("t5_busy", 32'(uart_tx_busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t5_count0", 32'(fifo_count), 32'd0);
      chk("t5_empty", 32'(fifo_empty), 32'd1);
      chk("t5_still_busy", 32'(uart_tx_busy), 32'd1);
      wait_idle("t5_idle", 200);
      repeat (5) @(negedge clk);
      chk("t5_pulses", 32'(en_pulses), 32'd1);
      chk("t5_rx0", 32'(rx_q[0]), 32'h55);
      chk("t5_idle_after", 32'(tx_idle), 32'd1);

      // Test 6: reset during F_WAIT_DONE with items queued.
      clear_obs();
      push(8'hA0);
      repeat (5) @(negedge clk);
      chk("t6_wait_done", 32'(dut.state_q), 32'd3);
      for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i));
      chk("t6_count4", 32'(fifo_count), 32'd4);
      do_reset();
      chk("t6_count", 32'(fifo_count), 32'd0);
      chk("t6_en", 32'(uart_tx_en), 32'd0);
      chk("t6_data", 32'(uart_tx_data), 32'd0);
      chk("t6_ready", 32'(wr_if.wr_ready), 32'd1);
      chk("t6_busy", 32'(uart_tx_busy), 32'd0);
      clear_obs();
      push(8'hB1);
      chk("t6_en_lat", 32'(uart_tx_en), 32'd0);
      @(negedge clk);
      chk("t6_en_post", 32'(uart_tx_en), 32'd1);
      chk("t6_data_post", 32'(uart_tx_data), 32'hB1);
      wait_idle("t6_idle", 200);
      chk("t6_pulses", 32'(en_pulses), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit queue sitting directly upstream of the UART transmitter. It accepts bytes from a producer (CPU, debug formatter, or test logic) through a valid/ready write port and stores them in a circular buffer. It then feeds them one at a time to the transmitter's single-cycle enable / busy interface, so producers can burst data without watching the serial line rate.

Parameters:
PAYLOAD_BITS, 8, width of each queued item; must match the transmitter payload width.
DEPTH, 16, number of buffer entries; power of two, minimum 2.
ADDR_BITS (localparam), $clog2(DEPTH), pointer width; occupancy counter is ADDR_BITS+1 bits wide.

Ports:
clk  input  1  system clock; all logic on rising edge.
resetn  input  1  synchronous, active-low reset.
flush  input  1  synchronous queue clear; the item already handed to the transmitter is not aborted.
wr_valid  input  1  producer offers wr_data this cycle.
wr_ready  output  1  queue can accept; equals !fifo_full.
wr_data  input  PAYLOAD_BITS  item to enqueue.
fifo_count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
fifo_empty  output  1  fifo_count == 0.
fifo_full  output  1  fifo_count == DEPTH.
tx_idle  output  1  fifo_empty, feeder in F_IDLE and uart_tx_busy low; all data is on the wire.
uart_tx_busy  input  1  transmitter busy flag.
uart_tx_en  output  1  registered one-cycle launch pulse to the transmitter.
uart_tx_data  output  PAYLOAD_BITS  registered item; held stable from launch until the next launch.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - Read/write pointers and count go to 0; fifo_empty=1, fifo_full=0, wr_ready=1.
  - uart_tx_en=0, uart_tx_data=0, feeder goes to F_IDLE.
  - Storage array is not reset.
  - Reset mid-transfer abandons the in-flight handshake. The transmitter shares resetn, so both restart clean.
- Push: occurs when wr_valid && wr_ready. mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH (natural wrap), count+1.
- wr_valid while full: ignored, no state change, no error flag. The producer must hold the data.
- Pop: occurs only in the F_IDLE launch condition. rd_ptr increments modulo DEPTH, count-1.
- Push and pop on the same edge: count unchanged, both pointers advance.
- When full, wr_ready stays low even on a pop edge. wr_ready is derived from the registered count only; no combinational path from uart_tx_busy to wr_ready.
- Feeder FSM:
  - F_IDLE: if !fifo_empty && !uart_tx_busy, then uart_tx_data <= mem[rd_ptr], uart_tx_en <= 1, pop, go to F_LAUNCH. Otherwise stay.
  - F_LAUNCH (uart_tx_en high for exactly this one cycle): uart_tx_en <= 0, go to F_WAIT_BUSY.
  - F_WAIT_BUSY: if uart_tx_busy, go to F_WAIT_DONE. Otherwise stay; this guards the one-cycle latency between enable and busy.
  - F_WAIT_DONE: if !uart_tx_busy, go to F_IDLE.
- Minimum gap: a new launch cannot occur on the same edge as busy falling, because the F_WAIT_DONE -> F_IDLE step costs one cycle. The next launch follows on the next edge.
- Launch latency from the first push into an empty queue with the transmitter idle: push at edge N, launch decision at edge N+1, uart_tx_en high during cycle N+1..N+2.
- Flush:
  - Pointers and count go to 0; the pop is suppressed that cycle.
  - Flush has priority over a simultaneous push; the pushed item is discarded.
  - The feeder FSM is not reset, so an item already launched completes normally.
- Outputs are registered or decoded from registered count/state only.
- Whole-item ordering is strict FIFO.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 on consecutive cycles into a transmitter model with CYCLES_PER_BIT=4 -> three single-cycle uart_tx_en pulses, data 0x41, 0x42, 0x43 in order. fifo_count peaks at 2 then returns to 0; tx_idle=1 after the last stop bit.
2. Hold the transmitter model busy and push DEPTH+2 items (0x00..0x11) -> wr_ready=0 and fifo_full=1 once count=16. Items 0x10/0x11 are not accepted until the producer retries. Received stream is 0x00..0x0F, then the retried items.
3. Run 40 pushes across pointer wrap with interleaved pops -> received sequence equals pushed sequence, no duplicate or lost bytes; fifo_count never exceeds 16.
4. Push and pop on the same edge with count=5 -> count stays 5 and both pointers advance by 1.
5. Assert flush while item 0x55 is transmitting and 3 items are queued -> 0x55 completes on uart_txd, no further uart_tx_en, fifo_count=0, tx_idle=1 afterwards.
6. Pulse resetn low for one cycle during F_WAIT_DONE with 4 items queued -> next cycle fifo_count=0, uart_tx_en=0, uart_tx_data=0, wr_ready=1. The first push after reset launches normally.
